// File: rtl/rf_wb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package rf_wb_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} wb_state_t;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT   = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr_i, wrapping mod N.
// Purely combinational; no grant when enable_i is low.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  input  logic                 enable_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  localparam int unsigned IW = $clog2(N);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  // Scan N positions starting at ptr_i; the first pending request wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      idx = sum[IW-1:0];
      if (enable_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between NREQ writeback requesters.
// Round-robin valid/ready grant, one registered output stage, and a flush handshake
// (RUN -> DRAIN -> HALTED) that drains the output stage and blocks new grants.
// Optional feature: define RF_WB_STATS_EN to add the stall_cnt output.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned AW   = AW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 we3,
  output logic [AW-1:0]        a3,
  output logic [XLEN-1:0]      wd3
`ifdef RF_WB_STATS_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(NREQ);

  wb_state_t       state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            we3_q, we3_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            flush_done_q, flush_done_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            grant_en;
  logic            accept;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  // Grants only in RUN, never while a flush is being requested or reset is held.
  assign grant_en = reset_n && (state_q == RUN) && !flush_req;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .enable_i  (grant_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready  = gnt;
  assign we3        = we3_q;
  assign a3         = a3_q;
  assign wd3        = wd3_q;
  assign flush_done = flush_done_q;

  // Request mux, flush FSM next state and output-stage next state.
  always_comb begin
    accept   = |(req_valid & gnt);
    sel_rd   = req_rd[gnt_idx*AW +: AW];
    sel_data = req_data[gnt_idx*XLEN +: XLEN];

    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   state_d = HALTED;
      HALTED:  if (!flush_req) state_d = RUN;
      default: state_d = RUN;
    endcase

    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // x0 is hardwired zero: the write is accepted and latched but never enabled.
    we3_d        = accept && (sel_rd != '0);
    a3_d         = accept ? sel_rd : a3_q;
    wd3_d        = accept ? sel_data : wd3_q;
    flush_done_d = (state_d == HALTED);
  end

  // FSM, round-robin pointer and registered write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= RUN;
      rr_ptr_q     <= '0;
      we3_q        <= 1'b0;
      a3_q         <= '0;
      wd3_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      we3_q        <= we3_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      flush_done_q <= flush_done_d;
    end
  end

`ifdef RF_WB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles where some valid requester was left waiting; saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|(req_valid & ~gnt)) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: the driver pushes expected regfile writes on
// every grant, and a negedge monitor pops and compares whenever we3 is high.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 flush_req;
  logic                 flush_done;
  logic                 we3;
  logic [AW-1:0]        a3;
  logic [XLEN-1:0]      wd3;
`ifdef RF_WB_STATS_EN
  logic [31:0]          stall_cnt;
  logic [31:0]          stall_snap;
`endif

  rf_wb_arbiter #(
    .NREQ (NREQ),
    .XLEN (XLEN),
    .AW   (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .we3        (we3),
    .a3         (a3),
    .wd3        (wd3)
`ifdef RF_WB_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    req_rd[i*AW +: AW]       = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  // Drive valid for one cycle, check the grant mid-cycle and queue the expected write.
  task automatic drive_cycle(input string name, input logic [NREQ-1:0] valid,
                             input logic [NREQ-1:0] exp_ready);
    wr_t e;
    req_valid = valid;
    @(negedge clk);
    check(name, 64'(req_ready), 64'(exp_ready));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ready[i] && (req_rd[i*AW +: AW] != '0)) begin
        e.rd   = req_rd[i*AW +: AW];
        e.data = req_data[i*XLEN +: XLEN];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (we3 === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL write_unexpected: got a3=%0d wd3=%h expected no write", a3, wd3);
        end else begin
          e = exp_q.pop_front();
          if ((a3 !== e.rd) || (wd3 !== e.data)) begin
            n_errors++;
            $display("FAIL write_data: got a3=%0d wd3=%h expected a3=%0d wd3=%h",
                     a3, wd3, e.rd, e.data);
          end
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    flush_req = 1'b0;
    @(posedge clk);
    #1;
    // Reset: no grants even with everything valid; outputs cleared.
    drive_cycle("reset_ready", 3'b111, 3'b000);
    check("reset_we3", 64'(we3), 64'd0);
    check("reset_a3", 64'(a3), 64'd0);
    check("reset_wd3", 64'(wd3), 64'd0);
    check("reset_flush_done", 64'(flush_done), 64'd0);
    reset_n   = 1'b1;
    req_valid = '0;

    // Single write from requester 0.
    set_req(0, 5'd7, 32'hDEAD_BEEF);
    drive_cycle("single", 3'b001, 3'b001);
    drive_cycle("idle0", 3'b000, 3'b000);

    // Bring ptr back to 0 via requester 2.
    set_req(2, 5'd9, 32'h2222_0000);
    drive_cycle("req2", 3'b100, 3'b100);

    // Contention: all valid for 6 cycles, ptr 0 -> 0,1,2,0,1,2.
    set_req(0, 5'd1, 32'hA0A0_0000);
    set_req(1, 5'd2, 32'hB1B1_0001);
    set_req(2, 5'd3, 32'hC2C2_0002);
`ifdef RF_WB_STATS_EN
    stall_snap = stall_cnt;
`endif
    for (int k = 0; k < 6; k++) begin
      drive_cycle("contention", 3'b111, 3'(1 << (k % 3)));
    end
`ifdef RF_WB_STATS_EN
    check("stall_cnt_delta", 64'(stall_cnt - stall_snap), 64'd6);
`endif

    // x0 write: granted, latched, never enabled.
    set_req(1, 5'd0, 32'h0000_1234);
    drive_cycle("x0_ready", 3'b010, 3'b010);
    check("x0_we3", 64'(we3), 64'd0);
    check("x0_a3", 64'(a3), 64'd0);
    check("x0_wd3", 64'(wd3), 64'h1234);
    drive_cycle("idle1", 3'b000, 3'b000);
    check("idle_we3", 64'(we3), 64'd0);
    check("idle_wd3_hold", 64'(wd3), 64'h1234);

    // Wrap: ptr=2, valid=011 -> grant 0, ptr becomes 1.
    set_req(0, 5'd4, 32'h4444_4444);
    set_req(1, 5'd5, 32'h5555_5555);
    drive_cycle("wrap", 3'b011, 3'b001);
    drive_cycle("wrap_ptr", 3'b111, 3'b010);
    drive_cycle("idle2", 3'b000, 3'b000);

    // Flush while streaming from requester 0 (ptr=2).
    set_req(0, 5'd10, 32'h0000_00F0);
    drive_cycle("pre_flush", 3'b001, 3'b001);
    flush_req = 1'b1;
    set_req(0, 5'd11, 32'h0000_00F1);
    drive_cycle("flush_run", 3'b001, 3'b000);
    check("flush_done_drain", 64'(flush_done), 64'd0);
    drive_cycle("flush_drain", 3'b001, 3'b000);
    check("flush_done_halt", 64'(flush_done), 64'd1);
    drive_cycle("flush_halt", 3'b001, 3'b000);
    check("flush_done_hold", 64'(flush_done), 64'd1);
    flush_req = 1'b0;
    drive_cycle("flush_release", 3'b001, 3'b000);
    check("flush_done_clear", 64'(flush_done), 64'd0);
    drive_cycle("flush_resume", 3'b001, 3'b001);
    drive_cycle("idle3", 3'b000, 3'b000);

    // Reset mid-write: requester 1 accepted (ptr -> 2), reset next cycle.
    set_req(1, 5'd12, 32'h0000_00AB);
    drive_cycle("mid_write", 3'b010, 3'b010);
    reset_n = 1'b0;
    drive_cycle("rst_write", 3'b000, 3'b000);
    check("rst_write_we3", 64'(we3), 64'd0);
    reset_n = 1'b1;
    drive_cycle("rst_ptr", 3'b111, 3'b001);
    drive_cycle("idle4", 3'b000, 3'b000);

    // Reset mid-flush: halted arbiter returns to RUN.
    flush_req = 1'b1;
    drive_cycle("mf_run", 3'b000, 3'b000);
    drive_cycle("mf_drain", 3'b000, 3'b000);
    check("mf_flush_done", 64'(flush_done), 64'd1);
    reset_n   = 1'b0;
    flush_req = 1'b0;
    drive_cycle("mf_reset", 3'b000, 3'b000);
    check("mf_reset_flush_done", 64'(flush_done), 64'd0);
    reset_n = 1'b1;
    drive_cycle("mf_resume", 3'b001, 3'b001);
    drive_cycle("idle5", 3'b000, 3'b000);
    drive_cycle("idle6", 3'b000, 3'b000);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
